// File: rtl/misr_signature_analyzer.sv
// MISR response compactor for the BIST chain.
// Folds NUM_PATTERNS words into a signature and compares it with golden.
module misr_signature_analyzer #(
  parameter int               WIDTH        = 7,
  parameter logic [WIDTH-1:0] POLY         = 7'h03,
  parameter int               NUM_PATTERNS = 127,
  parameter int               CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] golden,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_PATTERNS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] gold_q, gold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] misr_nxt;
  logic             fb;

  // Shift up, fold the MSB back through the taps, then absorb the word.
  always_comb begin
    fb       = sig_q[WIDTH-1];
    misr_nxt = {sig_q[WIDTH-2:0], 1'b0}
             ^ (POLY & {WIDTH{fb}})
             ^ din;
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    gold_d  = gold_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d   = '0;
          cnt_d   = '0;
          gold_d  = golden;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (din_valid) begin
          sig_d = misr_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = CHECK;
        end
      end
      CHECK: begin
        pass_d  = (sig_q == gold_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= '0;
      gold_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      gold_q  <= gold_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Scoreboard bench for misr_signature_analyzer.
// Two instances: a 2-word run and a full 127-word LFSR run.
module tb_misr_signature_analyzer;

  typedef struct {
    logic [6:0] sig;
    logic       pass;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start2 = 0, dv2 = 0;
  logic [6:0] gold2 = 0, din2 = 0;
  logic       busy2, done2, pass2;
  logic [6:0] sig2;
  logic [7:0] cnt2;

  logic       start7 = 0, dv7 = 0;
  logic [6:0] gold7 = 0, din7 = 0;
  logic       busy7, done7, pass7;
  logic [6:0] sig7;
  logic [7:0] cnt7;

  int n_chk = 0;
  int n_fail = 0;

  exp_t q2[$];
  exp_t q7[$];
  logic d2_prev = 0;
  logic d7_prev = 0;

  always #5 clk = ~clk;

  misr_signature_analyzer #(
    .WIDTH(7), .POLY(7'h03),
    .NUM_PATTERNS(2), .CNT_W(8)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .start(start2), .golden(gold2),
    .din_valid(dv2), .din(din2),
    .busy(busy2), .done(done2),
    .pass(pass2), .signature(sig2),
    .count(cnt2)
  );

  misr_signature_analyzer #(
    .WIDTH(7), .POLY(7'h03),
    .NUM_PATTERNS(127), .CNT_W(8)
  ) u7 (
    .clk(clk), .rst_n(rst_n),
    .start(start7), .golden(gold7),
    .din_valid(dv7), .din(din7),
    .busy(busy7), .done(done7),
    .pass(pass7), .signature(sig7),
    .count(cnt7)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [6:0] step(
    input logic [6:0] s, input logic [6:0] d);
    logic [6:0] r;
    r = {s[5:0], 1'b0} ^ d;
    if (s[6]) r = r ^ 7'h03;
    return r;
  endfunction

  // Monitors: pop one expectation per rising edge of done.
  always @(negedge clk) begin
    exp_t e;
    if (done2 && !d2_prev) begin
      if (q2.size() == 0) begin
        chk("u2_unexpected_done", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("u2_sig", sig2, e.sig);
        chk("u2_pass", pass2, e.pass);
        chk("u2_count", cnt2, e.cnt);
        chk("u2_busy_low", busy2, 0);
      end
    end
    if (done7 && !d7_prev) begin
      if (q7.size() == 0) begin
        chk("u7_unexpected_done", 1, 0);
      end else begin
        e = q7.pop_front();
        chk("u7_sig", sig7, e.sig);
        chk("u7_pass", pass7, e.pass);
        chk("u7_count", cnt7, e.cnt);
        chk("u7_busy_low", busy7, 0);
      end
    end
    d2_prev = done2;
    d7_prev = done7;
  end

  task automatic start_u2(input logic [6:0] g);
    start2 = 1; gold2 = g;
    @(posedge clk); #1;
    start2 = 0;
  endtask

  task automatic beat_u2(input logic [6:0] d,
                         input logic [6:0] es);
    dv2 = 1; din2 = d;
    @(posedge clk); #1;
    dv2 = 0; din2 = 0;
    chk("u2_beat_sig", sig2, es);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic full_run(input int flip);
    logic [6:0] l, m, g, w;
    l = 7'h01; g = 7'h00;
    for (int k = 0; k < 127; k++) begin
      g = step(g, l);
      l = step(l, 7'h00);
    end
    l = 7'h01; m = 7'h00;
    for (int k = 0; k < 127; k++) begin
      w = (k == flip) ? (l ^ 7'h04) : l;
      m = step(m, w);
      l = step(l, 7'h00);
    end
    q7.push_back('{sig: m, pass: (m == g),
                   cnt: 8'd127});
    start7 = 1; gold7 = g;
    @(posedge clk); #1;
    start7 = 0;
    l = 7'h01;
    for (int k = 0; k < 127; k++) begin
      w = (k == flip) ? (l ^ 7'h04) : l;
      dv7 = 1; din7 = w;
      @(posedge clk); #1;
      l = step(l, 7'h00);
    end
    dv7 = 0; din7 = 0;
    chk("u7_final_sig", sig7, m);
    idle(2);
  endtask

  initial begin
    // Reset state
    #7;
    chk("rst_sig", sig2, 0);
    chk("rst_count", cnt2, 0);
    chk("rst_flags", {busy2, done2, pass2}, 0);
    chk("rst_flags7", {busy7, done7, pass7}, 0);
    idle(2);
    rst_n = 1;
    idle(1);

    // Reset mid-run aborts with no result
    start7 = 1; gold7 = 7'h11;
    @(posedge clk); #1;
    start7 = 0;
    dv7 = 1; din7 = 7'h15;
    idle(2);
    dv7 = 0;
    chk("mid_count", cnt7, 2);
    chk("mid_busy", busy7, 1);
    rst_n = 0;
    #2;
    chk("arst_sig", sig7, 0);
    chk("arst_count", cnt7, 0);
    chk("arst_flags", {busy7, done7, pass7}, 0);
    rst_n = 1;
    dv7 = 1; din7 = 7'h33;
    idle(3);
    dv7 = 0;
    chk("idle_ignore_cnt", cnt7, 0);
    chk("idle_ignore_sig", sig7, 0);
    chk("idle_busy", busy7, 0);

    // No feedback
    q2.push_back('{sig: 7'h0A, pass: 1, cnt: 2});
    start_u2(7'h0A);
    chk("run_busy", busy2, 1);
    beat_u2(7'h05, 7'h05);
    beat_u2(7'h00, 7'h0A);
    chk("check_done_low", done2, 0);
    idle(1);
    chk("nf_done", done2, 1);
    idle(1);

    // Feedback path
    q2.push_back('{sig: 7'h03, pass: 0, cnt: 2});
    start_u2(7'h00);
    beat_u2(7'h40, 7'h40);
    beat_u2(7'h00, 7'h03);
    idle(2);

    // Gaps plus a stray start with a new golden
    q2.push_back('{sig: 7'h0A, pass: 1, cnt: 2});
    start_u2(7'h0A);
    beat_u2(7'h05, 7'h05);
    din2 = 7'h7F;
    idle(1);
    start2 = 1; gold2 = 7'h55;
    idle(1);
    start2 = 0;
    idle(1);
    chk("gap_sig", sig2, 7'h05);
    chk("gap_count", cnt2, 1);
    beat_u2(7'h00, 7'h0A);
    idle(2);

    // din_valid in DONE is ignored
    dv2 = 1; din2 = 7'h7F;
    idle(2);
    dv2 = 0;
    chk("done_hold_sig", sig2, 7'h0A);
    chk("done_hold_cnt", cnt2, 2);
    chk("done_hold_done", done2, 1);

    // Restart from DONE with a beat in the start cycle
    q2.push_back('{sig: 7'h0A, pass: 1, cnt: 2});
    dv2 = 1; din2 = 7'h7F;
    start_u2(7'h0A);
    dv2 = 0;
    chk("rs_sig", sig2, 0);
    chk("rs_count", cnt2, 0);
    chk("rs_flags", {done2, pass2}, 0);
    chk("rs_busy", busy2, 1);
    beat_u2(7'h05, 7'h05);
    beat_u2(7'h00, 7'h0A);
    idle(2);

    // Full LFSR runs, clean then corrupted
    full_run(-1);
    full_run(60);

    for (int i = 0; i < 20; i++) begin
      if (q2.size() == 0 && q7.size() == 0) break;
      idle(1);
    end
    chk("q2_drained", q2.size(), 0);
    chk("q7_drained", q7.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/misr_signature_analyzer.md
Name: misr_signature_analyzer

Overview:
- Response-compaction stage of the BIST chain, directly downstream of the 7-stage pattern LFSR.
- Compacts a fixed number of WIDTH-bit response words into a Multiple-Input Signature Register (MISR).
- Compares the final signature against a golden value and reports done/pass to the BIST controller.

Parameters:
- WIDTH, 7, data and signature width.
- POLY, 7'h03, feedback taps; bit i set means an x^i term (default is x^7 + x + 1). Bit 0 must be set.
- NUM_PATTERNS, 127, number of accepted words per run. Legal range is 1 .. 2^CNT_W-1.
- CNT_W, 8, width of the pattern counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run. Sampled only in IDLE or DONE.
- golden  in  WIDTH  expected signature; latched on an accepted start.
- din_valid  in  1  response word valid; qualifies din.
- din  in  WIDTH  response word from the circuit under test.
- busy  out  1  high in RUN and CHECK.
- done  out  1  high in DONE; held until the next accepted start or reset.
- pass  out  1  compare result; valid while done=1, 0 otherwise.
- signature  out  WIDTH  current MISR contents (registered).
- count  out  CNT_W  number of words accepted in the current run.

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - state = IDLE
  - signature = 0, count = 0, golden_q = 0
  - busy = 0, done = 0, pass = 0
- Reset asserted mid-run aborts the run with no result; after release the block waits in IDLE.
- State machine:
  - IDLE: start=1 → signature<=0, count<=0, golden_q<=golden, done<=0, pass<=0, go to RUN.
  - RUN: on each cycle with din_valid=1, update the MISR and do count<=count+1. If count==NUM_PATTERNS-1 on that beat, go to CHECK. Cycles with din_valid=0 leave all state unchanged.
  - CHECK: exactly one cycle. pass<=(signature==golden_q), done<=1, go to DONE.
  - DONE: hold signature, count, pass and done. start=1 → same actions as from IDLE, go to RUN.
- MISR update, with S = signature and d = din, for each bit i:
  - next[i] = (i>0 ? S[i-1] : 0) ^ (POLY[i] & S[WIDTH-1]) ^ d[i]
- Latency:
  - The final beat is accepted at edge N; signature is final after N.
  - done and pass are valid after edge N+1.
  - busy falls at the same edge (N+1).
- start while in RUN or CHECK is ignored: no restart, and golden is not re-latched.
- din_valid outside RUN is ignored: signature and count do not change.
- start and din_valid high in the same cycle in IDLE/DONE: only start acts. The beat is not accepted, because the MISR is cleared that cycle.
- count never wraps. It stops at NUM_PATTERNS and holds that value through DONE.
- golden changes after start have no effect; only golden_q is compared.
- All outputs are driven directly from flops, with no combinational paths from inputs.

Test Plan:
- Reset mid-run: NUM_PATTERNS=4, accept 2 words, pulse rst_n low → signature=0, count=0, busy=0, done=0, pass=0 immediately (asynchronous). start is required to resume.
- No feedback: NUM_PATTERNS=2, golden=7'h0A, start, din 7'h05 then 7'h00 (both valid) → signature 7'h05 then 7'h0A. One cycle after the last beat: done=1, pass=1, count=2, busy=0.
- Feedback path: NUM_PATTERNS=2, golden=7'h00, din 7'h40 then 7'h00 → signature 7'h40 then 7'h03, done=1, pass=0.
- Valid gaps and ignored inputs: NUM_PATTERNS=2, din_valid pulsed with 3 idle cycles between beats, and start pulsed during RUN → result identical to the no-feedback case. golden_q is unchanged by the mid-run start.
- Full run with the LFSR: NUM_PATTERNS=127, drive din from the LFSR Result (seed 7'h01), golden set from a software model → pass=1 and count=127. Rerun with one bit flipped on beat 60 → pass=0.
- Restart from DONE: after a completed run, start with din_valid=1 in the same cycle → that beat is not accepted. signature=0, count=0, done=0, pass=0 on the next cycle, and the new run completes normally.
